// File: rtl/pipeline_fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch stage (master) and memory (slave).
interface pipeline_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/pipeline_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited requests to instruction memory and queues
// returned words in order for Decode; redirects flush the queue and kill wrong-path responses.
module pipeline_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stallF,
  input  logic                  BranchTakenE,
  input  logic [31:0]           ALUResultE,
  input  logic                  PCSrcW,
  input  logic [31:0]           ResultW,
  input  logic                  PCW_DEM,
  pipeline_fetch_unit_if.master imem,
  output logic                  validF,
  output logic [31:0]           InstrF,
  output logic [31:0]           PCPlus4F
);
  localparam int QPW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [QPW-1:0] QLAST   = QPW'(FIFO_DEPTH - 1);
  localparam logic [TPW-1:0] TLAST   = TPW'(MAX_OUTSTANDING - 1);
  localparam logic [OW-1:0]  OUT_MAX = OW'(MAX_OUTSTANDING);
  localparam logic [31:0]    DEPTH_U = 32'(FIFO_DEPTH);

  function automatic logic [QPW-1:0] q_inc(input logic [QPW-1:0] p);
    return (p == QLAST) ? '0 : p + QPW'(1);
  endfunction

  function automatic logic [TPW-1:0] t_inc(input logic [TPW-1:0] p);
    return (p == TLAST) ? '0 : p + TPW'(1);
  endfunction

  // Control state
  logic [31:0]    pc_q, pc_d;
  logic           run_q;
  logic [OW-1:0]  out_q, out_d;
  logic [OW-1:0]  kill_q, kill_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [QPW-1:0] q_wr_q, q_wr_d, q_rd_q, q_rd_d;
  logic [TPW-1:0] t_wr_q, t_wr_d, t_rd_q, t_rd_d;

  // Data storage: response queue and per-request PC+4 tags (not reset)
  logic [31:0] q_instr_q [FIFO_DEPTH];
  logic [31:0] q_pc4_q   [FIFO_DEPTH];
  logic [31:0] tag_q     [MAX_OUTSTANDING];

  logic        redirect, credit_ok, req, xfer, resp, push, pop;
  logic [31:0] target;

  always_comb begin
    redirect  = BranchTakenE | PCSrcW;
    target    = (BranchTakenE ? ALUResultE : ResultW) & 32'hFFFF_FFFC;
    // Only issue when every in-flight response already owns a queue slot
    credit_ok = (out_q < OUT_MAX) && ((32'(out_q) + 32'(cnt_q)) < DEPTH_U);
    req       = run_q & ~PCW_DEM & ~redirect & credit_ok;
    xfer      = req & imem.imem_gnt;
    resp      = imem.imem_rvalid & (out_q != '0);
    push      = resp & ~redirect & (kill_q == '0);
    pop       = (cnt_q != '0) & ~stallF;

    pc_d = pc_q;
    if (redirect)  pc_d = target;
    else if (xfer) pc_d = pc_q + 32'd4;

    out_d = out_q + OW'(xfer) - OW'(resp);

    // Killed responses are always the oldest in flight, so a counter suffices
    kill_d = kill_q;
    if (redirect)                    kill_d = out_q - OW'(resp);
    else if (resp && kill_q != '0)   kill_d = kill_q - OW'(1);

    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    q_wr_d = push ? q_inc(q_wr_q) : q_wr_q;
    q_rd_d = pop  ? q_inc(q_rd_q) : q_rd_q;
    if (redirect) begin
      cnt_d  = '0;
      q_rd_d = q_wr_q;
    end

    t_wr_d = xfer ? t_inc(t_wr_q) : t_wr_q;
    t_rd_d = resp ? t_inc(t_rd_q) : t_rd_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= RESET_PC;
      run_q  <= 1'b0;
      out_q  <= '0;
      kill_q <= '0;
      cnt_q  <= '0;
      q_wr_q <= '0;
      q_rd_q <= '0;
      t_wr_q <= '0;
      t_rd_q <= '0;
    end else begin
      pc_q   <= pc_d;
      run_q  <= 1'b1;
      out_q  <= out_d;
      kill_q <= kill_d;
      cnt_q  <= cnt_d;
      q_wr_q <= q_wr_d;
      q_rd_q <= q_rd_d;
      t_wr_q <= t_wr_d;
      t_rd_q <= t_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) tag_q[t_wr_q] <= pc_q + 32'd4;
    if (push) begin
      q_instr_q[q_wr_q] <= imem.imem_rdata;
      q_pc4_q[q_wr_q]   <= tag_q[t_rd_q];
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;

  assign validF   = (cnt_q != '0);
  assign InstrF   = validF ? q_instr_q[q_rd_q] : 32'h0;
  assign PCPlus4F = validF ? q_pc4_q[q_rd_q]   : 32'h0;

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!reset)
    !(imem.imem_rvalid && out_q == '0));

endmodule

// File: tb/tb_pipeline_fetch_unit.sv
// Cycle-stepped bench for pipeline_fetch_unit: randomized memory latency/grant against a
// queue-based reference of in-flight requests and delivered instructions.
module tb_pipeline_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int DEPTH = 2;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallF, BranchTakenE, PCSrcW, PCW_DEM;
  logic [31:0] ALUResultE, ResultW;
  logic        validF;
  logic [31:0] InstrF, PCPlus4F;

  pipeline_fetch_unit_if bus();

  pipeline_fetch_unit #(
    .RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset(reset), .stallF(stallF), .BranchTakenE(BranchTakenE),
    .ALUResultE(ALUResultE), .PCSrcW(PCSrcW), .ResultW(ResultW), .PCW_DEM(PCW_DEM),
    .imem(bus), .validF(validF), .InstrF(InstrF), .PCPlus4F(PCPlus4F)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; bit killed; } fl_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc4; } qe_t;

  fl_t         fl[$];
  qe_t         q[$];
  logic [31:0] m_pc;
  bit          m_run;
  bit          rand_gnt;
  int          cyc, last_due, lat_min, lat_max;
  int          checks, passed;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic drive_mem();
    bus.imem_gnt = rand_gnt ? 1'($urandom_range(1, 0)) : 1'b1;
    if (fl.size() > 0 && fl[0].due <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = memf(fl[0].addr);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
    end
  endtask

  // Compare outputs for the current cycle, then advance the reference across the clock edge
  task automatic step();
    logic        exp_req, redir;
    logic [31:0] tgt;
    fl_t         e;
    qe_t         h;
    int          lat;
    #1;
    redir   = BranchTakenE | PCSrcW;
    exp_req = m_run && !PCW_DEM && !redir && (fl.size() < MAXO) && (fl.size() + q.size() < DEPTH);
    check("imem_req", 32'(bus.imem_req), 32'(exp_req));
    check("imem_addr", bus.imem_addr, m_pc);
    if (q.size() > 0) h = q[0];
    else begin
      h.instr = 32'h0;
      h.pc4   = 32'h0;
    end
    check("validF", 32'(validF), 32'(q.size() > 0));
    check("InstrF", InstrF, h.instr);
    check("PCPlus4F", PCPlus4F, h.pc4);

    if (q.size() > 0 && !stallF) void'(q.pop_front());
    if (bus.imem_rvalid) begin
      e = fl.pop_front();
      if (!redir && !e.killed) q.push_back('{memf(e.addr), e.addr + 32'd4});
    end
    if (redir) begin
      q.delete();
      foreach (fl[i]) fl[i].killed = 1'b1;
      tgt  = BranchTakenE ? ALUResultE : ResultW;
      m_pc = {tgt[31:2], 2'b00};
    end else if (exp_req && bus.imem_gnt) begin
      lat      = $urandom_range(lat_max, lat_min);
      e.addr   = m_pc;
      e.due    = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      e.killed = 1'b0;
      last_due = e.due;
      fl.push_back(e);
      m_pc = m_pc + 32'd4;
    end
    m_run = 1'b1;
    @(posedge clk);
    cyc++;
    #1 drive_mem();
  endtask

  task automatic redirect(input logic bt, input logic [31:0] alu, input logic ps, input logic [31:0] res);
    BranchTakenE = bt;
    ALUResultE   = alu;
    PCSrcW       = ps;
    ResultW      = res;
    step();
    BranchTakenE = 1'b0;
    PCSrcW       = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(bus.imem_req), 32'h0);
    check({tag, "_addr"}, bus.imem_addr, RESET_PC);
    check({tag, "_validF"}, 32'(validF), 32'h0);
    check({tag, "_InstrF"}, InstrF, 32'h0);
    check({tag, "_PCPlus4F"}, PCPlus4F, 32'h0);
  endtask

  task automatic model_reset();
    fl.delete();
    q.delete();
    m_pc     = RESET_PC;
    m_run    = 1'b0;
    last_due = cyc;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
  endtask

  initial begin
    checks = 0; passed = 0; cyc = 0; last_due = 0;
    lat_min = 1; lat_max = 1; rand_gnt = 1'b0;
    stallF = 0; BranchTakenE = 0; PCSrcW = 0; PCW_DEM = 0;
    ALUResultE = 0; ResultW = 0;
    reset = 1'b1;
    model_reset();
    #1 reset = 1'b0;
    #1 check_reset_outputs("por");
    @(negedge clk);
    #1 reset = 1'b1;
    drive_mem();

    // Streaming with single-cycle memory
    repeat (12) step();

    // Decode stall
    stallF = 1'b1;
    repeat (4) step();
    stallF = 1'b0;
    repeat (8) step();

    // Redirect with two responses in flight
    lat_min = 4; lat_max = 4;
    repeat (4) step();
    redirect(1'b1, 32'h0000_0100, 1'b0, 32'h0);
    repeat (14) step();

    // Execute redirect wins over Writeback
    redirect(1'b1, 32'h0000_0200, 1'b1, 32'h0000_0300);
    repeat (10) step();

    // Misaligned Writeback target, then PC wrap at top of address space
    lat_min = 1; lat_max = 2;
    redirect(1'b0, 32'h0, 1'b1, 32'h0000_0303);
    repeat (6) step();
    redirect(1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
    repeat (10) step();

    // PC write pending with variable latency and random grant
    lat_min = 1; lat_max = 4; rand_gnt = 1'b1;
    repeat (3) step();
    PCW_DEM = 1'b1;
    repeat (3) step();
    PCW_DEM = 1'b0;
    repeat (10) step();

    // Random soak
    repeat (400) begin
      stallF  = ($urandom_range(3, 0) == 0);
      PCW_DEM = ($urandom_range(9, 0) == 0);
      if ($urandom_range(19, 0) == 0) begin
        logic bt, ps;
        bt = 1'($urandom_range(1, 0));
        ps = !bt || ($urandom_range(1, 0) == 1);
        redirect(bt, $urandom, ps, $urandom);
      end else begin
        step();
      end
    end
    stallF = 1'b0; PCW_DEM = 1'b0;

    // Asynchronous reset mid-stream
    repeat (3) step();
    #2 reset = 1'b0;
    #1 check_reset_outputs("mid");
    model_reset();
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    #1 reset = 1'b1;
    lat_min = 1; lat_max = 1; rand_gnt = 1'b0;
    drive_mem();
    repeat (12) step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
